// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus: single outstanding request, data qualified by ack.
// The fetch unit is the master; the memory model or controller is the slave.
interface instr_fetch_if #(
  parameter int PCW = 10,
  parameter int IW  = 9
);
  logic           req;
  logic [PCW-1:0] addr;
  logic           ack;
  logic [IW-1:0]  rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at a time, holds it until the decoder
// consumes it, then advances PC sequentially, redirects on branch or stops on halt.
module instr_fetch #(
  parameter int PCW = 10,
  parameter int IW  = 9
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stall,
  input  logic                i_branch,
  input  logic [PCW-1:0]      i_target,
  input  logic                i_halt,
  instr_fetch_if.master       imem,
  output logic [IW-1:0]       o_instr,
  output logic                o_instr_valid,
  output logic [PCW-1:0]      o_pc,
  output logic                o_done,
  output logic [15:0]         o_fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALTED} state_t;

  state_t         r_state, w_state_nxt;
  logic [PCW-1:0] r_pc, w_pc_nxt;
  logic [IW-1:0]  r_instr, w_instr_nxt;
  logic           r_valid, w_valid_nxt;
  logic           r_done, w_done_nxt;
  logic [15:0]    r_cnt, w_cnt_nxt;
  logic           w_consume;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Valid is only ever set in HOLD, so this is the decoder's consume strobe.
  assign w_consume = r_valid & ~i_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_pc_nxt    = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (imem.ack) begin
          w_instr_nxt = imem.rdata;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = sat_inc16(r_cnt);
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_consume) begin
          w_valid_nxt = 1'b0;
          if (i_halt) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_HALTED;
          end else begin
            w_pc_nxt    = i_branch ? i_target : r_pc + PCW'(1);
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HALTED: begin
        if (i_start) begin
          w_done_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_pc_nxt    = '0;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign imem.req      = (r_state == S_REQ);
  assign imem.addr     = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_valid;
  assign o_pc          = r_pc;
  assign o_done        = r_done;
  assign o_fetch_count = r_cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle-by-cycle vector table plus hand-written
// sequences for stall, delayed ack, PC wrap and reset in the middle of a fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stall, branch, halt;
  logic [9:0]  target;
  logic [8:0]  instr;
  logic        instr_valid;
  logic [9:0]  pc;
  logic        done;
  logic [15:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_if #(.PCW(10), .IW(9)) bus ();

  instr_fetch #(.PCW(10), .IW(9)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_stall       (stall),
    .i_branch      (branch),
    .i_target      (target),
    .i_halt        (halt),
    .imem          (bus.master),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_done        (done),
    .o_fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, sl, br;
    logic [9:0]  tg;
    logic        hl, ak;
    logic [8:0]  rd;
    logic        req;
    logic [9:0]  addr;
    logic        vld;
    logic [8:0]  ins;
    logic [9:0]  pc;
    logic        dn;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(logic st, logic sl, logic br, logic [9:0] tg, logic hl,
                              logic ak, logic [8:0] rd, logic req, logic [9:0] addr,
                              logic vld, logic [8:0] ins, logic [9:0] p, logic dn,
                              logic [15:0] cnt);
    vec_t v;
    v.st = st; v.sl = sl; v.br = br; v.tg = tg; v.hl = hl; v.ak = ak; v.rd = rd;
    v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.pc = p; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic [9:0] addr,
                           input logic vld, input logic [8:0] ins, input logic [9:0] p,
                           input logic dn, input logic [15:0] cnt);
    check({tag, ".req"},   32'(bus.req),     32'(req));
    check({tag, ".addr"},  32'(bus.addr),    32'(addr));
    check({tag, ".valid"}, 32'(instr_valid), 32'(vld));
    check({tag, ".instr"}, 32'(instr),       32'(ins));
    check({tag, ".pc"},    32'(pc),          32'(p));
    check({tag, ".done"},  32'(done),        32'(dn));
    check({tag, ".count"}, 32'(fetch_count), 32'(cnt));
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic apply(input logic st, input logic sl, input logic br, input logic [9:0] tg,
                       input logic hl, input logic ak, input logic [8:0] rd);
    @(negedge clk);
    start = st; stall = sl; branch = br; target = tg; halt = hl;
    bus.ack = ak; bus.rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          st sl br tg      hl ak rd      | req addr    vld ins     pc      dn cnt
    vt[0]  = mk(1, 0, 0, 10'h0,  0, 0, 9'h0,     1, 10'h0,   0, 9'h0,   10'h0,  0, 16'd0);
    vt[1]  = mk(0, 0, 0, 10'h0,  0, 1, 9'h080,   0, 10'h0,   1, 9'h080, 10'h0,  0, 16'd1);
    vt[2]  = mk(0, 0, 0, 10'h0,  0, 0, 9'h0,     1, 10'h1,   0, 9'h080, 10'h1,  0, 16'd1);
    vt[3]  = mk(0, 0, 0, 10'h0,  0, 1, 9'h0A1,   0, 10'h1,   1, 9'h0A1, 10'h1,  0, 16'd2);
    vt[4]  = mk(0, 0, 0, 10'h0,  0, 0, 9'h0,     1, 10'h2,   0, 9'h0A1, 10'h2,  0, 16'd2);
    vt[5]  = mk(0, 0, 0, 10'h0,  0, 1, 9'h140,   0, 10'h2,   1, 9'h140, 10'h2,  0, 16'd3);
    vt[6]  = mk(0, 1, 1, 10'h12, 0, 0, 9'h0,     0, 10'h2,   1, 9'h140, 10'h2,  0, 16'd3);
    vt[7]  = mk(1, 1, 0, 10'h0,  0, 1, 9'h1FF,   0, 10'h2,   1, 9'h140, 10'h2,  0, 16'd3);
    vt[8]  = mk(0, 0, 0, 10'h0,  0, 0, 9'h0,     1, 10'h3,   0, 9'h140, 10'h3,  0, 16'd3);
    vt[9]  = mk(1, 0, 1, 10'h55, 1, 0, 9'h0,     1, 10'h3,   0, 9'h140, 10'h3,  0, 16'd3);
    vt[10] = mk(0, 0, 0, 10'h0,  0, 1, 9'h1FF,   0, 10'h3,   1, 9'h1FF, 10'h3,  0, 16'd4);
    vt[11] = mk(0, 0, 0, 10'h0,  0, 0, 9'h0,     1, 10'h4,   0, 9'h1FF, 10'h4,  0, 16'd4);
    vt[12] = mk(0, 0, 0, 10'h0,  0, 1, 9'h011,   0, 10'h4,   1, 9'h011, 10'h4,  0, 16'd5);
    vt[13] = mk(0, 0, 0, 10'h0,  0, 0, 9'h0,     1, 10'h5,   0, 9'h011, 10'h5,  0, 16'd5);
    vt[14] = mk(0, 0, 0, 10'h0,  0, 1, 9'h0AA,   0, 10'h5,   1, 9'h0AA, 10'h5,  0, 16'd6);
    vt[15] = mk(0, 0, 1, 10'h12, 0, 0, 9'h0,     1, 10'h12,  0, 9'h0AA, 10'h12, 0, 16'd6);
    vt[16] = mk(0, 0, 0, 10'h0,  0, 1, 9'h123,   0, 10'h12,  1, 9'h123, 10'h12, 0, 16'd7);
    vt[17] = mk(0, 0, 1, 10'h30, 1, 0, 9'h0,     0, 10'h12,  0, 9'h123, 10'h12, 1, 16'd7);
    vt[18] = mk(0, 0, 0, 10'h0,  0, 1, 9'h0FF,   0, 10'h12,  0, 9'h123, 10'h12, 1, 16'd7);
    vt[19] = mk(0, 0, 0, 10'h0,  0, 0, 9'h0,     0, 10'h12,  0, 9'h123, 10'h12, 1, 16'd7);
    vt[20] = mk(1, 0, 0, 10'h0,  0, 0, 9'h0,     1, 10'h0,   0, 9'h123, 10'h0,  0, 16'd0);
    vt[21] = mk(0, 0, 0, 10'h0,  0, 1, 9'h080,   0, 10'h0,   1, 9'h080, 10'h0,  0, 16'd1);

    rst_n = 1'b0;
    start = 0; stall = 0; branch = 0; target = '0; halt = 0;
    bus.ack = 1'b0; bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 10'h0, 0, 9'h0, 10'h0, 0, 16'd0);

    // Ack while idle after release must not start anything.
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 10'h0, 0, 1, 9'h1AB);
    check_all("idle_ack", 0, 10'h0, 0, 9'h0, 10'h0, 0, 16'd0);

    for (int i = 0; i < 22; i++) begin
      apply(vt[i].st, vt[i].sl, vt[i].br, vt[i].tg, vt[i].hl, vt[i].ak, vt[i].rd);
      check_all($sformatf("v%0d", i), vt[i].req, vt[i].addr, vt[i].vld, vt[i].ins,
                vt[i].pc, vt[i].dn, vt[i].cnt);
    end

    // Stall held for four cycles in HOLD.
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 10'h0, 0, 0, 9'h0);
      check_all($sformatf("stall%0d", i), 0, 10'h0, 1, 9'h080, 10'h0, 0, 16'd1);
    end
    apply(0, 0, 0, 10'h0, 0, 0, 9'h0);
    check_all("stall_rel", 1, 10'h1, 0, 9'h080, 10'h1, 0, 16'd1);

    // Ack delayed three cycles: request and address stay put.
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 10'h0, 0, 0, 9'h0);
      check_all($sformatf("ackdly%0d", i), 1, 10'h1, 0, 9'h080, 10'h1, 0, 16'd1);
    end
    apply(0, 0, 0, 10'h0, 0, 1, 9'h0A1);
    check_all("ackdly_ack", 0, 10'h1, 1, 9'h0A1, 10'h1, 0, 16'd2);

    // Branch to the top address, then sequential step wraps to 0.
    apply(0, 0, 1, 10'h3FF, 0, 0, 9'h0);
    check_all("wrap_br", 1, 10'h3FF, 0, 9'h0A1, 10'h3FF, 0, 16'd2);
    apply(0, 0, 0, 10'h0, 0, 1, 9'h042);
    check_all("wrap_ack", 0, 10'h3FF, 1, 9'h042, 10'h3FF, 0, 16'd3);
    apply(0, 0, 0, 10'h0, 0, 0, 9'h0);
    check_all("wrap_pc", 1, 10'h0, 0, 9'h042, 10'h0, 0, 16'd3);

    // Asynchronous reset in the middle of REQ, then a late ack.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all("rst_async", 0, 10'h0, 0, 9'h0, 10'h0, 0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 10'h0, 0, 1, 9'h155);
    check_all("late_ack", 0, 10'h0, 0, 9'h0, 10'h0, 0, 16'd0);
    apply(0, 0, 0, 10'h0, 0, 0, 9'h0);
    check_all("stay_idle", 0, 10'h0, 0, 9'h0, 10'h0, 0, 16'd0);
    apply(1, 0, 0, 10'h0, 0, 0, 9'h0);
    check_all("restart", 1, 10'h0, 0, 9'h0, 10'h0, 0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
